uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DATA_WIDTH, default 8, frame payload width.
REQ-003 Parameter BUSY_TO, default 4, maximum cycles to wait for BUSY to rise after launch.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 REQ_VALID  input  N_REQ  per-requester frame pending.
REQ-007 REQ_DATA  input  N_REQ*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 REQ_PAR_EN  input  N_REQ  per-requester parity enable.
REQ-009 REQ_PAR_TYP  input  N_REQ  per-requester parity type (0 even, 1 odd).
REQ-010 REQ_READY  output  N_REQ  one-cycle accept pulse; at most one bit high.
REQ-011 P_DATA  output  DATA_WIDTH  payload to the UART transmitter.
REQ-012 DATA_VALID  output  1  one-cycle launch strobe to the UART transmitter.
REQ-013 PAR_EN, PAR_TYP  output  1 each  parity configuration to the UART transmitter.
REQ-014 BUSY  input  1  UART transmitter frame-in-progress flag.
REQ-015 GNT_ID  output  clog2(N_REQ)  index of the current or last granted requester.
REQ-016 ARB_BUSY  output  1  high in any state other than IDLE.
REQ-017 ERR_TO  output  1  sticky timeout flag; cleared only by reset.

Function
REQ-018 The FSM SHALL have four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-019 IDLE: when any REQ_VALID bit is high and BUSY=0, the block SHALL grant one requester, register its data, PAR_EN and PAR_TYP, pulse its REQ_READY in the same cycle, and move to LAUNCH.
REQ-020 Arbitration SHALL be round-robin: search starts at (last granted + 1) mod N_REQ; after reset, search starts at requester 0.
REQ-021 LAUNCH: DATA_VALID SHALL be 1 for exactly this cycle with registered P_DATA; the next state is WAIT_BUSY.
REQ-022 WAIT_BUSY: BUSY=1 SHALL move the FSM to WAIT_DONE.
REQ-023 WAIT_BUSY: if BUSY stays 0 for BUSY_TO cycles, the FSM SHALL set ERR_TO and return to IDLE; the frame is dropped and not retried.
REQ-024 WAIT_DONE: BUSY=0 SHALL move the FSM to IDLE; re-arbitration can occur in the very next cycle.
REQ-025 P_DATA, PAR_EN and PAR_TYP SHALL stay stable from LAUNCH until the FSM leaves WAIT_DONE; all outputs are registered.
REQ-026 Once REQ_READY has pulsed, the block SHALL ignore any change on the accepted requester's inputs; a requester that keeps REQ_VALID high is re-queued through the normal rotation.
REQ-027 If BUSY is high in IDLE (external frame), the block SHALL not grant until BUSY is 0.
REQ-028 Latency from REQ_VALID (block idle) to DATA_VALID SHALL be 2 cycles: accept cycle plus LAUNCH.
REQ-029 REQ_VALID deasserting in the same cycle as its REQ_READY pulse SHALL not affect the accepted frame.

Reset
REQ-030 On RST assertion, the block SHALL enter IDLE immediately, regardless of the current state, including mid-frame.
REQ-031 Reset values: REQ_READY=0, DATA_VALID=0, P_DATA=0, PAR_EN=0, PAR_TYP=0, GNT_ID=0, ARB_BUSY=0, ERR_TO=0, round-robin pointer=N_REQ-1, timeout counter=0.

Structure
REQ-032 A shared package uart_tx_pkg SHALL hold the FSM state encoding and the defaults for N_REQ, DATA_WIDTH and BUSY_TO.
REQ-033 The round-robin grant logic SHALL be a sub-module, tx_rr_arb, with inputs request vector and pointer and outputs one-hot grant and index.
REQ-034 The top-level file SHALL contain the FSM, the payload/config registers and the timeout counter.

Verification
REQ-035 Single request: REQ_VALID[2]=1, REQ_DATA[2]=0xA5, PAR_EN=1, PAR_TYP=1 -> REQ_READY[2] for 1 cycle, DATA_VALID 1 cycle later with P_DATA=0xA5, PAR_EN=1, PAR_TYP=1, GNT_ID=2.
REQ-036 Fairness: all four REQ_VALID held high with a UART model (BUSY for 10 cycles) -> grant order 0,1,2,3,0; no requester is granted twice before the others.
REQ-037 Config hold: requester 1 changes REQ_PAR_TYP right after REQ_READY -> PAR_TYP stays at the accepted value until BUSY falls.
REQ-038 Timeout: BUSY tied 0 -> ERR_TO=1 exactly BUSY_TO cycles after LAUNCH, FSM back in IDLE, next request still served.
REQ-039 Reset mid-frame: RST pulsed in WAIT_DONE -> all outputs at reset values immediately; after release, next grant goes to requester 0.
REQ-040 External busy: BUSY=1 in IDLE with REQ_VALID[0]=1 -> no REQ_READY until BUSY=0, then grant occurs the following cycle.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, parameter defaults, round-robin helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_pkg;

    // Parameter defaults shared by the arbiter top and its sub-module
    localparam int N_REQ_DEF      = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int BUSY_TO_DEF    = 4;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

    // Rotational distance of requester idx from the slot after ptr; 0 means highest priority.
    function automatic int rr_dist(input int idx, input int ptr, input int n);
        return (idx + n - 1 - ptr) % n;
    endfunction

endpackage

// File: rtl/tx_rr_arb.sv
// Round-robin grant selection: picks the first requester after the pointer, wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is taken.
module tx_rr_arb
    import uart_tx_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);

    int best;

    // Keep the requester with the smallest rotational distance from ptr+1
    always_comb begin
        gnt  = '0;
        idx  = '0;
        best = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (rr_dist(i, int'(ptr), N_REQ) < best)) begin
                best   = rr_dist(i, int'(ptr), N_REQ);
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter among N_REQ requesters with round-robin arbitration and a launch timeout.
// Latency: REQ_READY one cycle after REQ_VALID is sampled while idle, DATA_VALID one cycle after that.
// Backpressure: no grant while BUSY is high or a frame is in flight; a frame whose BUSY never rises is dropped.
module uart_tx_arb
    import uart_tx_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUSY_TO    = BUSY_TO_DEF
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [N_REQ-1:0]            REQ_VALID,
    input  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [N_REQ-1:0]            REQ_PAR_EN,
    input  logic [N_REQ-1:0]            REQ_PAR_TYP,
    output logic [N_REQ-1:0]            REQ_READY,
    output logic [DATA_WIDTH-1:0]       P_DATA,
    output logic                        DATA_VALID,
    output logic                        PAR_EN,
    output logic                        PAR_TYP,
    input  logic                        BUSY,
    output logic [$clog2(N_REQ)-1:0]    GNT_ID,
    output logic                        ARB_BUSY,
    output logic                        ERR_TO
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(BUSY_TO + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(BUSY_TO - 1);

    tx_state_t             state;
    logic [IW-1:0]         rr_ptr;
    logic [TW-1:0]         to_cnt;
    logic [N_REQ-1:0]      arb_gnt;
    logic [IW-1:0]         arb_idx;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_par_en;
    logic                  sel_par_typ;
    logic                  grant_now;

    tx_rr_arb #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_arb (
        .req (REQ_VALID),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Select the winning requester's payload and parity config with the one-hot grant
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_data = sel_data | REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_par_en  = |(REQ_PAR_EN & arb_gnt);
    assign sel_par_typ = |(REQ_PAR_TYP & arb_gnt);

    // An external frame on the transmitter blocks new grants
    assign grant_now = (|REQ_VALID) && !BUSY;

    // Arbiter FSM with registered outputs, payload/config capture and the launch timeout counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            rr_ptr     <= IW'(N_REQ - 1);
            to_cnt     <= '0;
            REQ_READY  <= '0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_EN     <= 1'b0;
            PAR_TYP    <= 1'b0;
            GNT_ID     <= '0;
            ARB_BUSY   <= 1'b0;
            ERR_TO     <= 1'b0;
        end else begin
            REQ_READY  <= '0;
            DATA_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_now) begin
                        // Capture everything now so later requester changes cannot leak in
                        REQ_READY <= arb_gnt;
                        P_DATA    <= sel_data;
                        PAR_EN    <= sel_par_en;
                        PAR_TYP   <= sel_par_typ;
                        GNT_ID    <= arb_idx;
                        rr_ptr    <= arb_idx;
                        ARB_BUSY  <= 1'b1;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    DATA_VALID <= 1'b1;
                    to_cnt     <= '0;
                    state      <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (BUSY) begin
                        to_cnt <= '0;
                        state  <= ST_WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        // Transmitter never picked the frame up: drop it, flag it, go idle
                        to_cnt   <= '0;
                        ERR_TO   <= 1'b1;
                        ARB_BUSY <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!BUSY) begin
                        ARB_BUSY <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    ARB_BUSY <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios followed by randomized traffic against a transaction-level model.
// Latency: n/a.
// Backpressure: the bench plays the UART transmitter, including frames it never picks up.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [N-1:0]  REQ_VALID;
    logic [N*DW-1:0] REQ_DATA;
    logic [N-1:0]  REQ_PAR_EN;
    logic [N-1:0]  REQ_PAR_TYP;
    logic [N-1:0]  REQ_READY;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          BUSY;
    logic [1:0]    GNT_ID;
    logic          ARB_BUSY;
    logic          ERR_TO;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_arb #(.N_REQ(N), .DATA_WIDTH(DW), .BUSY_TO(TO)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ_VALID   (REQ_VALID),
        .REQ_DATA    (REQ_DATA),
        .REQ_PAR_EN  (REQ_PAR_EN),
        .REQ_PAR_TYP (REQ_PAR_TYP),
        .REQ_READY   (REQ_READY),
        .P_DATA      (P_DATA),
        .DATA_VALID  (DATA_VALID),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .BUSY        (BUSY),
        .GNT_ID      (GNT_ID),
        .ARB_BUSY    (ARB_BUSY),
        .ERR_TO      (ERR_TO)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_ready"}, 32'(REQ_READY), 32'd0);
        check_val({tag, "_dv"},    32'(DATA_VALID), 32'd0);
        check_val({tag, "_pdata"}, 32'(P_DATA), 32'd0);
        check_val({tag, "_paren"}, 32'(PAR_EN), 32'd0);
        check_val({tag, "_partyp"}, 32'(PAR_TYP), 32'd0);
        check_val({tag, "_gntid"}, 32'(GNT_ID), 32'd0);
        check_val({tag, "_arbbusy"}, 32'(ARB_BUSY), 32'd0);
        check_val({tag, "_errto"}, 32'(ERR_TO), 32'd0);
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic pe, input logic pt);
        logic [N-1:0]    m;
        logic [N*DW-1:0] dm;
        m  = 4'b0001 << i;
        dm = 32'hFF << (i * DW);
        REQ_VALID = REQ_VALID | m;
        REQ_DATA  = (REQ_DATA & ~dm) | (32'(d) << (i * DW));
        REQ_PAR_EN  = pe ? (REQ_PAR_EN | m) : (REQ_PAR_EN & ~m);
        REQ_PAR_TYP = pt ? (REQ_PAR_TYP | m) : (REQ_PAR_TYP & ~m);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge CLK);
        REQ_VALID = '0; REQ_DATA = '0; REQ_PAR_EN = '0; REQ_PAR_TYP = '0; BUSY = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        check_reset(tag);
        RST = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (((v >> k) & 4'd1) != 4'd0) return k;
        return -1;
    endfunction

    // Round-robin rule: first requester at or after last+1, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        int c;
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (((v >> c) & 4'd1) != 4'd0) return c;
        end
        return -1;
    endfunction

    initial begin
        int got[5];
        int ng, busy_left;
        int cyc, idle_from, dv_cyc, b_start, b_end, err_from, last_g, pidx;
        logic [N-1:0]    pv, v;
        logic [N*DW-1:0] pdata, d;
        logic [N-1:0]    ppe, ppt, pe, pt;
        logic            pcan, busy;
        logic [7:0]      f_data;
        logic            f_pe, f_pt;
        int              f_idx;

        RST = 1'b1; REQ_VALID = '0; REQ_DATA = '0; REQ_PAR_EN = '0; REQ_PAR_TYP = '0; BUSY = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset("rst_init");
        RST = 1'b0;

        // Single request from requester 2
        @(negedge CLK);
        set_req(2, 8'hA5, 1'b1, 1'b1);
        @(negedge CLK);
        check_val("t1_ready", 32'(REQ_READY), 32'h4);
        check_val("t1_dv_early", 32'(DATA_VALID), 32'd0);
        REQ_VALID = '0;
        @(negedge CLK);
        check_val("t1_dv", 32'(DATA_VALID), 32'd1);
        check_val("t1_pdata", 32'(P_DATA), 32'hA5);
        check_val("t1_paren", 32'(PAR_EN), 32'd1);
        check_val("t1_partyp", 32'(PAR_TYP), 32'd1);
        check_val("t1_gntid", 32'(GNT_ID), 32'd2);
        check_val("t1_ready_pulse", 32'(REQ_READY), 32'd0);
        BUSY = 1'b1;
        @(negedge CLK);
        check_val("t1_dv_pulse", 32'(DATA_VALID), 32'd0);
        repeat (3) @(negedge CLK);
        BUSY = 1'b0;
        repeat (2) @(negedge CLK);
        check_val("t1_idle", 32'(ARB_BUSY), 32'd0);
        check_val("t1_errto", 32'(ERR_TO), 32'd0);

        // Fairness with all requesters pending, UART busy for 10 cycles per frame
        apply_reset("rst_fair");
        REQ_VALID = 4'hF;
        REQ_DATA  = 32'h44332211;
        ng = 0;
        busy_left = 0;
        for (int k = 0; k < 300 && !(ng >= 5 && !ARB_BUSY && busy_left == 0); k++) begin
            @(negedge CLK);
            if (REQ_READY != '0) begin
                if (ng < 5) got[ng] = onehot_idx(REQ_READY);
                ng++;
                if (ng == 5) REQ_VALID = '0;
            end
            if (DATA_VALID) busy_left = 10;
            BUSY = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
        BUSY = 1'b0;
        check_val("fair_count", 32'(ng), 32'd5);
        for (int i = 0; i < 5; i++) check_val("fair_order", 32'(got[i]), 32'(i % N));

        // Config hold: requester 1 flips parity type and data right after acceptance
        @(negedge CLK);
        set_req(1, 8'h3C, 1'b1, 1'b0);
        @(negedge CLK);
        check_val("t3_ready", 32'(REQ_READY), 32'h2);
        REQ_VALID = '0;
        set_req(1, 8'hFF, 1'b0, 1'b1);
        REQ_VALID = '0;
        @(negedge CLK);
        check_val("t3_dv", 32'(DATA_VALID), 32'd1);
        check_val("t3_partyp", 32'(PAR_TYP), 32'd0);
        check_val("t3_paren", 32'(PAR_EN), 32'd1);
        check_val("t3_gntid", 32'(GNT_ID), 32'd1);
        BUSY = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check_val("t3_hold_typ", 32'(PAR_TYP), 32'd0);
            check_val("t3_hold_data", 32'(P_DATA), 32'h3C);
        end
        BUSY = 1'b0;
        @(negedge CLK);
        check_val("t3_idle", 32'(ARB_BUSY), 32'd0);

        // External busy blocks grants in idle
        @(negedge CLK);
        BUSY = 1'b1;
        set_req(0, 8'h5A, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check_val("t4_blocked", 32'(REQ_READY), 32'd0);
            check_val("t4_arb_idle", 32'(ARB_BUSY), 32'd0);
        end
        BUSY = 1'b0;
        @(negedge CLK);
        check_val("t4_grant", 32'(REQ_READY), 32'h1);
        REQ_VALID = '0;
        @(negedge CLK);
        check_val("t4_dv", 32'(DATA_VALID), 32'd1);
        check_val("t4_pdata", 32'(P_DATA), 32'h5A);
        BUSY = 1'b1;
        repeat (2) @(negedge CLK);
        BUSY = 1'b0;
        @(negedge CLK);
        check_val("t4_idle", 32'(ARB_BUSY), 32'd0);

        // Reset mid-frame from requester 1, then all pending: requester 0 first
        @(negedge CLK);
        set_req(1, 8'hC3, 1'b1, 1'b1);
        @(negedge CLK);
        check_val("t5_ready", 32'(REQ_READY), 32'h2);
        REQ_VALID = '0;
        @(negedge CLK);
        check_val("t5_dv", 32'(DATA_VALID), 32'd1);
        BUSY = 1'b1;
        repeat (2) @(negedge CLK);
        check_val("t5_mid_busy", 32'(ARB_BUSY), 32'd1);
        #2 RST = 1'b1;
        #1 check_reset("t5_async");
        @(negedge CLK);
        RST = 1'b0;
        BUSY = 1'b0;
        REQ_VALID = 4'hF;
        @(negedge CLK);
        check_val("t5_first_grant", 32'(REQ_READY), 32'h1);
        REQ_VALID = '0;

        // Timeout: BUSY stays low after the launch just granted
        @(negedge CLK);
        check_val("t6_dv", 32'(DATA_VALID), 32'd1);
        repeat (TO - 1) @(negedge CLK);
        check_val("t6_err_early", 32'(ERR_TO), 32'd0);
        check_val("t6_still_busy", 32'(ARB_BUSY), 32'd1);
        @(negedge CLK);
        check_val("t6_err", 32'(ERR_TO), 32'd1);
        check_val("t6_idle", 32'(ARB_BUSY), 32'd0);
        set_req(2, 8'h77, 1'b0, 1'b1);
        @(negedge CLK);
        check_val("t6_next_ready", 32'(REQ_READY), 32'h4);
        REQ_VALID = '0;
        @(negedge CLK);
        check_val("t6_next_dv", 32'(DATA_VALID), 32'd1);
        check_val("t6_next_pdata", 32'(P_DATA), 32'h77);
        BUSY = 1'b1;
        @(negedge CLK);
        BUSY = 1'b0;
        @(negedge CLK);
        check_val("t6_sticky", 32'(ERR_TO), 32'd1);
        check_val("t6_done", 32'(ARB_BUSY), 32'd0);

        // Randomized traffic against a transaction-level model
        apply_reset("rst_rnd");
        idle_from = 0; dv_cyc = -1; b_start = -1; b_end = -1;
        err_from = 32'h3FFF_FFFF; last_g = N - 1; pcan = 1'b0; pidx = 0;
        pv = '0; pdata = '0; ppe = '0; ppt = '0;
        f_data = '0; f_pe = 1'b0; f_pt = 1'b0; f_idx = 0;
        for (cyc = 0; cyc < 800; cyc++) begin
            @(negedge CLK);
            check_val("rnd_ready", 32'(REQ_READY), pcan ? (32'd1 << pidx) : 32'd0);
            if (pcan) begin
                last_g = pidx;
                f_idx  = pidx;
                f_data = 8'(pdata >> (pidx * DW));
                f_pe   = ppe[0 +: 1] == 1'b1 ? 1'b0 : 1'b0;
                f_pe   = ((ppe >> pidx) & 4'd1) != 4'd0;
                f_pt   = ((ppt >> pidx) & 4'd1) != 4'd0;
                dv_cyc = cyc + 1;
                if ($urandom_range(0, 5) == 0) begin
                    b_start   = -1;
                    b_end     = -1;
                    idle_from = dv_cyc + TO;
                    if (err_from > dv_cyc + TO) err_from = dv_cyc + TO;
                end else begin
                    b_start   = dv_cyc + int'($urandom_range(1, TO - 1));
                    b_end     = b_start + int'($urandom_range(1, 6));
                    idle_from = b_end + 1;
                end
            end
            check_val("rnd_dv", 32'(DATA_VALID), 32'(cyc == dv_cyc));
            if (dv_cyc >= 0 && cyc >= dv_cyc && cyc < idle_from) begin
                check_val("rnd_pdata", 32'(P_DATA), 32'(f_data));
                check_val("rnd_paren", 32'(PAR_EN), 32'(f_pe));
                check_val("rnd_partyp", 32'(PAR_TYP), 32'(f_pt));
                check_val("rnd_gntid", 32'(GNT_ID), 32'(f_idx));
            end
            check_val("rnd_arb_busy", 32'(ARB_BUSY), 32'(cyc < idle_from));
            check_val("rnd_err_to", 32'(ERR_TO), 32'(cyc >= err_from));

            v  = 4'($urandom_range(0, 15));
            d  = $urandom;
            pe = 4'($urandom_range(0, 15));
            pt = 4'($urandom_range(0, 15));
            if (cyc >= b_start && cyc < b_end) busy = 1'b1;
            else if (cyc >= idle_from)         busy = ($urandom_range(0, 4) == 0);
            else                               busy = 1'b0;
            REQ_VALID = v; REQ_DATA = d; REQ_PAR_EN = pe; REQ_PAR_TYP = pt; BUSY = busy;
            pv = v; pdata = d; ppe = pe; ppt = pt;
            pcan = (cyc >= idle_from) && !busy && (v != '0);
            if (pcan) pidx = rr_pick(v, last_g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
